conv_frame_encoder: RTL and testbench
=====================================

Name: conv_frame_encoder

Overview:
Upstream stage of the Viterbi decoder wrapper. It accepts a bit-serial data frame, convolutionally encodes it (rate 1/2, default K=3, G0=7, G1=5), appends K-1 zero tail bits, and drives the decoder's symbol/start serial interface. An optional single-symbol error injection lets the bench exercise correction. After the decoder reports frame completion, the block issues the release pulse that returns the decoder to idle.

Parameters:
K, 3, constraint length
G0, 3'b111, generator for symbol bit 1
G1, 3'b101, generator for symbol bit 0
MAX_FRAME, 64, decoder symbol buffer depth; data bits per frame ≤ MAX_FRAME-(K-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  data bit offered
in_bit  in  1  data bit value
in_last  in  1  marks final data bit of frame
in_ready  out  1  bit accepted when in_valid&&in_ready
err_en  in  1  enable error injection for this frame (sampled at first accepted bit)
err_idx  in  7  symbol index to corrupt (0-based, tail symbols included)
err_mask  in  2  XOR mask applied to that symbol
dec_rx_ready  in  1  decoder ready for symbols (uo_out[0])
dec_frame_done  in  1  decoder frame complete (uo_out[4])
sym_valid  out  1  one-cycle symbol strobe (to ui_in[0])
sym  out  2  {G0 parity, G1 parity} (to ui_in[2:1])
dec_start  out  1  one-cycle start/release pulse (to ui_in[3])
busy  out  1  state != IDLE
overflow  out  1  sticky: frame truncated at capacity; cleared on next frame's first bit

Behaviour:
- Reset: state=IDLE, shift reg=0, sym_count=0, sym_valid=0, sym=0, dec_start=0, overflow=0, in_ready=0.
- Encoder: window w={b, s[K-2:0]}, s[K-2] = most recent previous bit. sym[1]=^(w&G0), sym[0]=^(w&G1). Then s <= {b, s[K-2:1]}. s=0 at frame start.
- All outputs are registered. A bit accepted in cycle n produces sym_valid=1 in cycle n+1; back-to-back acceptance is allowed (1 symbol/cycle).
- Corruption: if err_en is latched and sym_count==err_idx, then sym ^= err_mask. An err_idx ≥ total symbol count means no corruption.
- States:
  - IDLE: in_ready = dec_rx_ready && !dec_frame_done. On the first accepted bit, clear overflow, latch err_en/err_idx/err_mask, and go to ENC (or TAIL if in_last).
  - ENC: in_ready = dec_rx_ready. On each accepted bit, emit a symbol and sym_count++. in_last, or acceptance of bit number MAX_FRAME-(K-1) without in_last, goes to TAIL. The capacity case also sets overflow=1 and holds in_ready=0 until IDLE.
  - TAIL: emit K-1 zero-input symbols on consecutive cycles (in_ready=0), then go to START.
  - START: pulse dec_start for 1 cycle, then go to WAIT_DONE.
  - WAIT_DONE: wait for dec_frame_done=1, then go to RELEASE.
  - RELEASE: pulse dec_start for 1 cycle, then go to DRAIN.
  - DRAIN: wait for dec_frame_done=0, then go to IDLE and clear s and sym_count.
- dec_rx_ready low during ENC: in_ready=0. A symbol already registered still completes.
- in_valid while in_ready=0 is ignored; the bit is not consumed.
- Reset mid-frame: immediate return to the reset state. The decoder is reset by the same rst.
- sym_count is 7 bits and never exceeds MAX_FRAME.

Decomposition:
- Shared package viterbi_pkg: K, G0, G1, MAX_FRAME, state enum, and a function conv_sym(w,G0,G1). The decoder side reuses the same function.
- One sub-module, conv_enc_core: shift register plus parity only, with ports (bit, en, clr) → (sym). The FSM, counters and error injection stay in the top.

Test Plan:
- Bits 1,0,1,1 (last on 4th), err_en=0 → sym sequence 11,10,00,01,01,11 on consecutive cycles; then one dec_start pulse.
- Same frame with err_en=1, err_idx=2, err_mask=2'b10 → third symbol is 10 and all others are unchanged.
- Hold dec_rx_ready=0 for 3 cycles mid-frame → in_ready=0 and no sym_valid during the hold; the sequence resumes intact.
- Feed 70 bits with no in_last → 62 data symbols and 2 tail symbols (64 total), overflow=1, in_ready=0 afterwards.
- Raise dec_frame_done 5 cycles after start → exactly one release pulse, state DRAIN until done falls, then IDLE; a second frame encodes from s=0.
- Assert rst during TAIL → all outputs 0 on the next cycle and busy=0.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared definitions for the convolutional encoder and the Viterbi decoder side:
// code parameters, FSM state encoding and the parity function both ends use.
package viterbi_pkg;

  localparam int         VIT_K         = 3;
  localparam logic [2:0] VIT_G0        = 3'b111;
  localparam logic [2:0] VIT_G1        = 3'b101;
  localparam int         VIT_MAX_FRAME = 64;

  // Widest window the parity helper accepts; callers zero-extend shorter windows.
  localparam int VIT_KMAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENC       = 3'd1,
    ST_TAIL      = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RELEASE   = 3'd5,
    ST_DRAIN     = 3'd6
  } state_e;

  // Symbol for window w: {parity under g0, parity under g1}.
  function automatic logic [1:0] conv_sym(input logic [VIT_KMAX-1:0] w,
                                          input logic [VIT_KMAX-1:0] g0,
                                          input logic [VIT_KMAX-1:0] g1);
    return {^(w & g0), ^(w & g1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2 convolutional encoder core: shift register plus combinational parity.
// The symbol reflects the current bit combined with the stored history.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter int           K  = VIT_K,
  parameter logic [K-1:0] G0 = VIT_G0,
  parameter logic [K-1:0] G1 = VIT_G1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_bit,
  input  logic       i_en,
  input  logic       i_clr,
  output logic [1:0] o_sym
);

  logic [K-2:0] r_s;
  logic [K-1:0] w_win;

  // r_s[K-2] holds the most recent previous bit.
  assign w_win = {i_bit, r_s};
  assign o_sym = conv_sym(VIT_KMAX'(w_win), VIT_KMAX'(G0), VIT_KMAX'(G1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_s <= '0;
    end else if (i_en) begin
      r_s <= w_win[K-1:1];
    end
  end

endmodule

// File: rtl/conv_frame_encoder.sv
// Frame encoder feeding the Viterbi decoder: encodes a bit-serial frame, appends
// the zero tail, optionally corrupts one symbol, and runs the start/release handshake.
module conv_frame_encoder
  import viterbi_pkg::*;
#(
  parameter int           K         = VIT_K,
  parameter logic [K-1:0] G0        = VIT_G0,
  parameter logic [K-1:0] G1        = VIT_G1,
  parameter int           MAX_FRAME = VIT_MAX_FRAME
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       err_en,
  input  logic [6:0] err_idx,
  input  logic [1:0] err_mask,
  input  logic       dec_rx_ready,
  input  logic       dec_frame_done,
  output logic       sym_valid,
  output logic [1:0] sym,
  output logic       dec_start,
  output logic       busy,
  output logic       overflow
);

  // Symbol index of the last data bit that still fits ahead of the tail.
  localparam logic [6:0] CAP_LAST  = 7'(MAX_FRAME - K);
  localparam logic [6:0] TAIL_LAST = 7'(K - 2);

  state_e     r_state;
  state_e     w_state_next;
  logic       r_accept_en;
  logic       r_sym_valid;
  logic [1:0] r_sym;
  logic       r_dec_start;
  logic       r_overflow;
  logic [6:0] r_sym_count;
  logic [6:0] r_tail_cnt;
  logic       r_err_en;
  logic [6:0] r_err_idx;
  logic [1:0] r_err_mask;

  logic       w_first;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_emit;
  logic       w_core_bit;
  logic       w_core_clr;
  logic       w_cap;
  logic       w_err_en;
  logic [6:0] w_err_idx;
  logic [1:0] w_err_mask;
  logic       w_hit;
  logic [1:0] w_core_sym;

  assign w_first    = (r_state == ST_IDLE);
  assign w_in_ready = r_accept_en && dec_rx_ready && !(w_first && dec_frame_done);
  assign w_accept   = in_valid && w_in_ready;
  assign w_emit     = w_accept || (r_state == ST_TAIL);
  assign w_core_bit = (r_state == ST_TAIL) ? 1'b0 : in_bit;
  assign w_core_clr = (r_state == ST_DRAIN) && !dec_frame_done;
  assign w_cap      = (r_sym_count == CAP_LAST);

  // The first symbol of a frame uses the live injection controls, later ones the latched copy.
  assign w_err_en   = w_first ? err_en   : r_err_en;
  assign w_err_idx  = w_first ? err_idx  : r_err_idx;
  assign w_err_mask = w_first ? err_mask : r_err_mask;
  assign w_hit      = w_err_en && (w_err_idx == r_sym_count);

  conv_enc_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .i_bit (w_core_bit),
    .i_en  (w_emit),
    .i_clr (w_core_clr),
    .o_sym (w_core_sym)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_ENC: begin
        if (w_accept) begin
          w_state_next = (in_last || w_cap) ? ST_TAIL : ST_ENC;
        end
      end
      ST_TAIL:      if (r_tail_cnt == TAIL_LAST) w_state_next = ST_START;
      ST_START:     w_state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (dec_frame_done) w_state_next = ST_RELEASE;
      ST_RELEASE:   w_state_next = ST_DRAIN;
      ST_DRAIN:     if (!dec_frame_done) w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_accept_en <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sym       <= 2'b00;
      r_dec_start <= 1'b0;
      r_overflow  <= 1'b0;
      r_sym_count <= 7'd0;
      r_tail_cnt  <= 7'd0;
      r_err_en    <= 1'b0;
      r_err_idx   <= 7'd0;
      r_err_mask  <= 2'b00;
    end else begin
      r_state     <= w_state_next;
      // Input acceptance and the start pulse follow the state being entered.
      r_accept_en <= (w_state_next == ST_IDLE) || (w_state_next == ST_ENC);
      r_dec_start <= (w_state_next == ST_START) || (w_state_next == ST_RELEASE);
      r_sym_valid <= w_emit;
      r_sym       <= w_emit ? (w_core_sym ^ (w_hit ? w_err_mask : 2'b00)) : 2'b00;
      r_tail_cnt  <= (r_state == ST_TAIL) ? r_tail_cnt + 7'd1 : 7'd0;

      if (w_emit) begin
        r_sym_count <= r_sym_count + 7'd1;
      end else if (w_core_clr) begin
        r_sym_count <= 7'd0;
      end

      if (w_accept && w_first) begin
        r_overflow <= 1'b0;
        r_err_en   <= err_en;
        r_err_idx  <= err_idx;
        r_err_mask <= err_mask;
      end
      if (w_accept && !in_last && w_cap) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign sym_valid = r_sym_valid;
  assign sym       = r_sym;
  assign dec_start = r_dec_start;
  assign overflow  = r_overflow;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Directed bench for conv_frame_encoder: table of frames with hand-computed symbol
// streams, plus sequences for backpressure, capacity overflow and reset mid-frame.
module tb_conv_frame_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       err_en = 1'b0;
  logic [6:0] err_idx = 7'd0;
  logic [1:0] err_mask = 2'b00;
  logic       dec_rx_ready = 1'b1;
  logic       dec_frame_done = 1'b0;
  logic       sym_valid;
  logic [1:0] sym;
  logic       dec_start;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  logic [1:0] q[$];
  int         stamps[$];

  conv_frame_encoder dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_bit         (in_bit),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .err_en         (err_en),
    .err_idx        (err_idx),
    .err_mask       (err_mask),
    .dec_rx_ready   (dec_rx_ready),
    .dec_frame_done (dec_frame_done),
    .sym_valid      (sym_valid),
    .sym            (sym),
    .dec_start      (dec_start),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sym_valid) begin
      q.push_back(sym);
      stamps.push_back(cyc);
    end
    if (dec_start) n_start = n_start + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         nbits;
    logic [7:0] bits;
    logic       e_en;
    logic [6:0] e_idx;
    logic [1:0] e_mask;
    int         nsyms;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_sym(input logic b, input logic [1:0] s);
    return {b ^ s[1] ^ s[0], b ^ s[0]};
  endfunction

  task automatic send_bit(input logic b, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int t = 0;
    while (n_start < 1 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, "_start_pulse"}, n_start, 1);
    repeat (5) @(posedge clk);
    #1;
    dec_frame_done = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_release_pulse"}, n_start, 2);
    chk({tag, "_drain_busy"}, busy, 1);
    dec_frame_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic check_syms(input vec_t v, input string tag);
    chk({tag, "_count"}, q.size(), v.nsyms);
    for (int i = 0; i < v.nsyms; i++) begin
      chk($sformatf("%s_sym%0d", tag, i), q[i], v.exp[15-2*i -: 2]);
    end
    if (q.size() == v.nsyms && v.nsyms > 1) begin
      chk({tag, "_consecutive"}, stamps[v.nsyms-1] - stamps[0], v.nsyms - 1);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    q.delete();
    stamps.delete();
    n_start  = 0;
    err_en   = v.e_en;
    err_idx  = v.e_idx;
    err_mask = v.e_mask;
    for (int i = 0; i < v.nbits; i++) begin
      send_bit(v.bits[i], (i == v.nbits - 1));
      if (i == 0) begin
        chk({tag, "_ovf_clear"}, overflow, 0);
        // Injection controls must have been latched with the first bit.
        err_en   = 1'b0;
        err_idx  = 7'h7f;
        err_mask = 2'b00;
      end
    end
    finish_frame(tag);
    check_syms(v, tag);
  endtask

  initial begin
    tbl[0] = '{4, 8'b00001101, 1'b0, 7'd0,  2'b00, 6, {2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 4'b0}};
    tbl[1] = '{4, 8'b00001101, 1'b1, 7'd2,  2'b10, 6, {2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 4'b0}};
    tbl[2] = '{4, 8'b00001101, 1'b1, 7'd5,  2'b11, 6, {2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 4'b0}};
    tbl[3] = '{4, 8'b00001101, 1'b1, 7'd40, 2'b11, 6, {2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 4'b0}};
    tbl[4] = '{4, 8'b00001101, 1'b1, 7'd0,  2'b01, 6, {2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 4'b0}};
    tbl[5] = '{1, 8'b00000001, 1'b0, 7'd0,  2'b00, 3, {2'b11, 2'b10, 2'b11, 10'b0}};
    tbl[6] = '{3, 8'b00000000, 1'b0, 7'd0,  2'b00, 5, {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b0}};
    tbl[7] = '{5, 8'b00000111, 1'b0, 7'd0,  2'b00, 7, {2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b0}};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_sym", sym, 0);
    chk("rst_dec_start", dec_start, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Idle acceptance is blocked while the decoder still reports done
    dec_frame_done = 1'b1;
    @(negedge clk);
    chk("idle_done_block", in_ready, 0);
    @(posedge clk);
    #1;
    dec_frame_done = 1'b0;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      run_vec(tbl[v], $sformatf("vec%0d", v));
    end

    // Decoder backpressure mid-frame
    q.delete();
    stamps.delete();
    n_start = 0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    dec_rx_ready = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold_in_ready%0d", c), in_ready, 0);
      @(posedge clk);
      #1;
    end
    chk("hold_sym_count", q.size(), 2);
    dec_rx_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    finish_frame("hold");
    chk("hold_count", q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("hold_sym%0d", i), q[i], tbl[0].exp[15-2*i -: 2]);
    end

    // Capacity overflow: 70 bits offered with no in_last
    begin
      logic       acc[$];
      logic [1:0] s;
      logic [1:0] e;
      int         nbad;
      q.delete();
      stamps.delete();
      n_start = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 70; c++) begin
        in_bit = (c % 3 == 0);
        @(negedge clk);
        if (in_ready) acc.push_back(in_bit);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("ovf_accepted", acc.size(), 62);
      chk("ovf_total_syms", q.size(), 64);
      chk("ovf_flag", overflow, 1);
      chk("ovf_in_ready", in_ready, 0);
      s = 2'b00;
      nbad = 0;
      for (int i = 0; i < 64; i++) begin
        if (i < acc.size()) begin
          e = ref_sym(acc[i], s);
          s = {acc[i], s[1]};
        end else begin
          e = ref_sym(1'b0, s);
          s = {1'b0, s[1]};
        end
        if (i < q.size() && q[i] !== e) nbad++;
      end
      chk("ovf_sym_values", nbad, 0);
      finish_frame("ovf");
      chk("ovf_sticky", overflow, 1);
    end
    run_vec(tbl[5], "after_ovf");

    // Reset while emitting tail symbols
    q.delete();
    n_start = 0;
    send_bit(1'b1, 1'b1);
    chk("tail_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("tailrst_sym_valid", sym_valid, 0);
    chk("tailrst_sym", sym, 0);
    chk("tailrst_dec_start", dec_start, 0);
    chk("tailrst_overflow", overflow, 0);
    chk("tailrst_in_ready", in_ready, 0);
    chk("tailrst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_vec(tbl[7], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
